// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO read scheduler.
package fifo_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  localparam int unsigned QUEUE_NUM_DEF = 4;
  localparam int unsigned BURST_LEN_DEF = 4;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_cbb.sv
// Combinational round-robin arbiter: searches upward from last_idx+1 (mod N),
// skipping requesters flagged in excl.
module rr_arb_cbb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [N-1:0]  req_m;
  logic [IW-1:0] cand;

  // First masked requester after the last grant, wrapping at N.
  always_comb begin
    req_m   = req & ~excl;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IW'((int'(last_idx) + k) % int'(N));
      if (!gnt_vld && req_m[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt_vld ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// N-queue round-robin read scheduler with bounded bursts and a registered
// valid/ready output stage tagged with the source queue id.
// Optional: define FIFO_RR_SCHED_PRIO0_EN to make queue 0 strict-high-priority.
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned QUEUE_NUM  = QUEUE_NUM_DEF,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned QID_WIDTH  = 2,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  input  logic [QUEUE_NUM-1:0]            q_empty,
  input  logic [QUEUE_NUM*DATA_WIDTH-1:0] q_rdata,
  output logic [QUEUE_NUM-1:0]            q_ren,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [QID_WIDTH-1:0]            out_qid,
  output logic                            sched_busy
);

  localparam int unsigned CNT_W = clog2_f(BURST_LEN + 1);

  if (QID_WIDTH != clog2_f(QUEUE_NUM)) begin : g_qid_chk
    $error("fifo_rr_sched: QID_WIDTH must equal ceil(log2(QUEUE_NUM))");
  end
  if (QUEUE_NUM < 2 || BURST_LEN < 1) begin : g_param_chk
    $error("fifo_rr_sched: need QUEUE_NUM >= 2 and BURST_LEN >= 1");
  end

  sched_state_e          state_q, state_d;
  logic [QID_WIDTH-1:0]  cur_q, cur_d;
  logic [QID_WIDTH-1:0]  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  load;
  logic [QID_WIDTH-1:0]  arb_last;
  logic [QUEUE_NUM-1:0]  arb_excl;
  logic [QUEUE_NUM-1:0]  arb_gnt;
  logic [QID_WIDTH-1:0]  arb_idx;
  logic                  arb_vld;
  logic                  prio_hit;

  logic                  pop_vld;
  logic                  pop_cont;
  logic                  pop_prio;
  logic [QID_WIDTH-1:0]  pop_idx;
  logic [DATA_WIDTH-1:0] rdata_sel;

  // The output register can take a new word when empty or being drained.
  assign load       = !out_valid || out_ready;
  assign sched_busy = (state_q == ST_BURST);

`ifdef FIFO_RR_SCHED_PRIO0_EN
  // Queue 0 pre-empts any arbitration except its own ongoing burst.
  assign prio_hit = !q_empty[0] && (state_q == ST_IDLE || cur_q != '0);
`else
  assign prio_hit = 1'b0;
`endif

  // Arbiter context: a finished/broken burst restarts the search after cur.
  always_comb begin
    arb_last = last_q;
    arb_excl = '0;
    if (state_q == ST_BURST) begin
      arb_last = cur_q;
      arb_excl = QUEUE_NUM'(1) << cur_q;
    end
  end

  rr_arb_cbb #(
    .N  (QUEUE_NUM),
    .IW (QID_WIDTH)
  ) u_arb (
    .req      (~q_empty),
    .last_idx (arb_last),
    .excl     (arb_excl),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .gnt_vld  (arb_vld)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      last_q  <= QID_WIDTH'(QUEUE_NUM - 1);
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state: burst counting, burst termination and new grants.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (load) begin
      if (state_q == ST_BURST && !pop_cont) begin
        state_d = ST_IDLE;
        last_d  = cur_q;
        cnt_d   = '0;
      end
      if (pop_cont) begin
        if (cnt_q + CNT_W'(1) == CNT_W'(BURST_LEN)) begin
          state_d = ST_IDLE;
          last_d  = cur_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (pop_vld && !pop_prio) begin
        cur_d = pop_idx;
        if (BURST_LEN > 1) begin
          state_d = ST_BURST;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          last_d  = pop_idx;
          cnt_d   = '0;
        end
      end
    end
  end

  // Output decode: pop selection and the combinational pop strobe.
  always_comb begin
    pop_vld  = 1'b0;
    pop_cont = 1'b0;
    pop_prio = 1'b0;
    pop_idx  = cur_q;
    q_ren    = '0;
    if (reset_n && load) begin
      if (prio_hit) begin
        pop_vld  = 1'b1;
        pop_prio = 1'b1;
        pop_idx  = '0;
        q_ren    = QUEUE_NUM'(1);
      end else if (state_q == ST_BURST && !q_empty[cur_q]) begin
        pop_vld  = 1'b1;
        pop_cont = 1'b1;
        pop_idx  = cur_q;
        q_ren    = QUEUE_NUM'(1) << cur_q;
      end else if (arb_vld) begin
        pop_vld = 1'b1;
        pop_idx = arb_idx;
        q_ren   = arb_gnt;
      end
    end
  end

  // Head-data mux for the popped queue.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < int'(QUEUE_NUM); i++) begin
      if (pop_idx == QID_WIDTH'(i)) begin
        rdata_sel = q_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Registered output stage; holds while stalled.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_qid   <= '0;
    end else if (load) begin
      out_valid <= pop_vld;
      if (pop_vld) begin
        out_data <= rdata_sel;
        out_qid  <= pop_idx;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched with a queue model feeding q_empty/q_rdata.
module tb_fifo_rr_sched;

  localparam int unsigned QN = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned QW = 2;
  localparam int unsigned BL = 4;

  logic             clk_sys;
  logic             reset_n;
  logic [QN-1:0]    q_empty;
  logic [QN*DW-1:0] q_rdata;
  logic [QN-1:0]    q_ren;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [QW-1:0]    out_qid;
  logic             sched_busy;

  logic [DW-1:0]    qm [QN][$];
  logic [QN-1:0]    ren_s;
  int               total;
  int               bad;

  fifo_rr_sched #(
    .QUEUE_NUM  (QN),
    .DATA_WIDTH (DW),
    .QID_WIDTH  (QW),
    .BURST_LEN  (BL)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .q_empty    (q_empty),
    .q_rdata    (q_rdata),
    .q_ren      (q_ren),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_qid    (out_qid),
    .sched_busy (sched_busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic drive_q();
    for (int i = 0; i < int'(QN); i++) begin
      q_empty[i] = (qm[i].size() == 0);
      q_rdata[i*DW +: DW] = (qm[i].size() == 0) ? '0 : qm[i][0];
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < int'(QN); i++) qm[i].delete();
  endtask

  // One clock: drive inputs after negedge, sample q_ren, pop model at posedge.
  task automatic step();
    drive_q();
    #1;
    ren_s = q_ren;
    total++;
    if ($countones(ren_s) > 1) begin
      bad++; $display("FAIL ren_onehot: got %b", ren_s);
    end
    total++;
    if ((ren_s & q_empty) !== '0) begin
      bad++; $display("FAIL ren_on_empty: ren %b empty %b", ren_s, q_empty);
    end
    @(posedge clk_sys);
    for (int i = 0; i < int'(QN); i++) begin
      if (ren_s[i] && qm[i].size() > 0) void'(qm[i].pop_front());
    end
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    out_ready = 1'b1;
    clear_q();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    out_ready = 1'b1;
    clear_q();
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h exp 00", out_data); end
    total++; if (out_qid !== 2'd0) begin bad++; $display("FAIL rst_qid: got %0d exp 0", out_qid); end
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b exp 0", sched_busy); end
    total++; if (ren_s !== 4'b0000) begin bad++; $display("FAIL rst_ren: got %b exp 0000", ren_s); end
    qm[1].push_back(8'h55);
    step();
    total++; if (ren_s !== 4'b0000) begin bad++; $display("FAIL rst_ren_gate: got %b exp 0000", ren_s); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_gate_valid: got %b exp 0", out_valid); end
    clear_q();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid[%0d]: got %b exp 0", k, out_valid); end
      total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL idle_busy[%0d]: got %b exp 0", k, sched_busy); end
      total++; if (ren_s !== 4'b0000) begin bad++; $display("FAIL idle_ren[%0d]: got %b exp 0000", k, ren_s); end
    end
  endtask

  task automatic test_single();
    logic [QN-1:0] er [7];
    logic          eb [7];
    er = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    eb = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int w = 0; w < 6; w++) qm[2].push_back(DW'(8'h10 + w));
    for (int k = 0; k < 7; k++) begin
      step();
      total++; if (ren_s !== er[k]) begin bad++; $display("FAIL single_ren[%0d]: got %b exp %b", k, ren_s, er[k]); end
      total++; if (out_valid !== (k < 6)) begin bad++; $display("FAIL single_valid[%0d]: got %b exp %b", k, out_valid, (k < 6)); end
      total++; if (sched_busy !== eb[k]) begin bad++; $display("FAIL single_busy[%0d]: got %b exp %b", k, sched_busy, eb[k]); end
      if (k < 6) begin
        total++; if (out_data !== DW'(8'h10 + k)) begin bad++; $display("FAIL single_data[%0d]: got %h exp %h", k, out_data, DW'(8'h10 + k)); end
        total++; if (out_qid !== 2'd2) begin bad++; $display("FAIL single_qid[%0d]: got %0d exp 2", k, out_qid); end
      end
    end
  endtask

  task automatic test_fairness();
    logic [QN-1:0] e;
    int            g;
    int            w;
    do_reset();
    for (int i = 0; i < int'(QN); i++)
      for (int j = 0; j < 8; j++) qm[i].push_back(DW'(i * 16 + j));
    for (int k = 0; k < 20; k++) begin
      g = (k / 4) % 4;
      w = (k / 16) * 4 + (k % 4);
      e = '0;
      e[g] = 1'b1;
      step();
      total++; if (ren_s !== e) begin bad++; $display("FAIL fair_ren[%0d]: got %b exp %b", k, ren_s, e); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fair_valid[%0d]: got %b exp 1", k, out_valid); end
      total++; if (out_data !== DW'(g * 16 + w)) begin bad++; $display("FAIL fair_data[%0d]: got %h exp %h", k, out_data, DW'(g * 16 + w)); end
      total++; if (out_qid !== QW'(g)) begin bad++; $display("FAIL fair_qid[%0d]: got %0d exp %0d", k, out_qid, g); end
    end
    clear_q();
    step();
    step();
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL fair_end_busy: got %b exp 0", sched_busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int w = 0; w < 6; w++) qm[1].push_back(DW'(8'hA0 + w));
    for (int w = 0; w < 4; w++) qm[2].push_back(DW'(8'hB0 + w));
    step();
    step();
    total++; if (out_data !== 8'hA1) begin bad++; $display("FAIL bp_pre_data: got %h exp a1", out_data); end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (ren_s !== 4'b0000) begin bad++; $display("FAIL bp_ren[%0d]: got %b exp 0000", k, ren_s); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b exp 1", k, out_valid); end
      total++; if (out_data !== 8'hA1) begin bad++; $display("FAIL bp_data[%0d]: got %h exp a1", k, out_data); end
      total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d]: got %b exp 1", k, sched_busy); end
    end
    out_ready = 1'b1;
    step();
    total++; if (ren_s !== 4'b0010) begin bad++; $display("FAIL bp_r0_ren: got %b exp 0010", ren_s); end
    total++; if (out_data !== 8'hA2) begin bad++; $display("FAIL bp_r0_data: got %h exp a2", out_data); end
    step();
    total++; if (ren_s !== 4'b0010) begin bad++; $display("FAIL bp_r1_ren: got %b exp 0010", ren_s); end
    total++; if (out_data !== 8'hA3) begin bad++; $display("FAIL bp_r1_data: got %h exp a3", out_data); end
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL bp_r1_busy: got %b exp 0", sched_busy); end
    step();
    total++; if (ren_s !== 4'b0100) begin bad++; $display("FAIL bp_next_ren: got %b exp 0100", ren_s); end
    total++; if (out_data !== 8'hB0) begin bad++; $display("FAIL bp_next_data: got %h exp b0", out_data); end
    total++; if (out_qid !== 2'd2) begin bad++; $display("FAIL bp_next_qid: got %0d exp 2", out_qid); end
  endtask

  task automatic test_early_end();
    logic [QN-1:0] er [5];
    logic [DW-1:0] ed [4];
    er = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000};
    ed = '{8'hC0, 8'hC1, 8'hD0, 8'hD1};
    do_reset();
    qm[1].push_back(8'hC0);
    qm[1].push_back(8'hC1);
    qm[3].push_back(8'hD0);
    qm[3].push_back(8'hD1);
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (ren_s !== er[k]) begin bad++; $display("FAIL early_ren[%0d]: got %b exp %b", k, ren_s, er[k]); end
      total++; if (out_valid !== (k < 4)) begin bad++; $display("FAIL early_valid[%0d]: got %b exp %b", k, out_valid, (k < 4)); end
      if (k < 4) begin
        total++; if (out_data !== ed[k]) begin bad++; $display("FAIL early_data[%0d]: got %h exp %h", k, out_data, ed[k]); end
      end
    end
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL early_busy: got %b exp 0", sched_busy); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    for (int w = 0; w < 4; w++) qm[0].push_back(DW'(8'hE0 + w));
    step();
    step();
    reset_n = 1'b0;
    step();
    total++; if (ren_s !== 4'b0000) begin bad++; $display("FAIL mid_rst_ren: got %b exp 0000", ren_s); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b exp 0", out_valid); end
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b exp 0", sched_busy); end
    reset_n = 1'b1;
    step();
    total++; if (ren_s !== 4'b0001) begin bad++; $display("FAIL mid_post_ren: got %b exp 0001", ren_s); end
    total++; if (out_data !== 8'hE2) begin bad++; $display("FAIL mid_post_data: got %h exp e2", out_data); end
    total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL mid_post_busy: got %b exp 1", sched_busy); end
    clear_q();
    step();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clear_q();
    drive_q();
    @(negedge clk_sys);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_early_end();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
